btn_debounce_ms: RTL and testbench
==================================

Name: btn_debounce_ms

Overview:
- Consumes the 1 ms clock-enable strobe (ce1ms) from the millisecond tick generator.
- Produces a clean, debounced push-button level plus single-cycle press, release, long-press and auto-repeat event pulses.
- Sits between a raw board pushbutton pin and the control logic, e.g. counters and display mode selection.
- All timing is counted in ce1ms ticks, never in raw clocks.

Parameters:
- T_DEB, 20, debounce interval in ms (ce1ms ticks); legal 2..255
- T_LONG, 1000, hold time in ms before long-press is declared; must be greater than T_DEB
- T_REP, 200, auto-repeat period in ms after long-press; legal 2..1023

Ports:
- clk  input  1  system clock (50 MHz)
- rst  input  1  synchronous reset, active-high
- ce1ms  input  1  1 ms clock-enable strobe, one clk cycle wide
- btn_in  input  1  raw asynchronous button, active-high
- btn_lvl  output  1  debounced button level
- btn_press  output  1  one-clk pulse on debounced press
- btn_release  output  1  one-clk pulse on debounced release
- btn_long  output  1  one-clk pulse when hold reaches T_LONG
- btn_rep  output  1  one-clk pulse every T_REP ms while long-held

Behaviour:
- Single clock domain (clk); reset is synchronous and active-high on rst.
- Reset: all outputs 0, synchroniser FFs 0, state IDLE, all counters 0. Reset mid-operation aborts silently (no release pulse).
- Input path: btn_in feeds a 2-FF synchroniser (s0, s1); the FSM sees s1 only. btn_in reaches s1 2 clk after change.
- Counters, each sized to $clog2(max+1) and saturating never needed:
  - dcnt: debounce counter
  - hcnt: hold counter
  - rcnt: repeat counter
- A held flag remembers whether long-press was already declared.
- FSM states: IDLE, DEB_DN, PRESSED, HELD, DEB_UP.
- IDLE: s1=1 -> DEB_DN, dcnt<=0.
- DEB_DN:
  - s1=0 -> IDLE (glitch rejected, no pulse). s1=0 has priority over a simultaneous ce1ms.
  - Else, on ce1ms, dcnt++. On the ce1ms where dcnt==T_DEB-1 -> PRESSED, btn_lvl<=1, btn_press<=1, hcnt<=0, held<=0.
- PRESSED:
  - s1=0 -> DEB_UP, dcnt<=0.
  - Else, on ce1ms, hcnt++. On the ce1ms where hcnt==T_LONG-1 -> HELD, btn_long<=1, rcnt<=0, held<=1.
- HELD:
  - s1=0 -> DEB_UP, dcnt<=0.
  - Else, on ce1ms, rcnt++. On the ce1ms where rcnt==T_REP-1 -> btn_rep<=1, rcnt<=0 (wrap).
- DEB_UP:
  - hcnt and rcnt are frozen.
  - s1=1 -> return to HELD if held, else PRESSED, counters resumed. This is bounce during release; no pulses.
  - Else, on ce1ms, dcnt++. On the ce1ms where dcnt==T_DEB-1 -> IDLE, btn_lvl<=0, btn_release<=1.
- Timing consequences:
  - ce1ms phase is unrelated to the input edge, so the debounce delay is (T_DEB-1, T_DEB] ms plus 3 clk.
  - Pulses are registered: asserted the clk after the qualifying ce1ms cycle, exactly one clk wide, then cleared.
  - btn_long and btn_rep are never asserted in the same cycle; the first btn_rep comes T_REP ticks after btn_long.
- ce1ms stuck high: every clk counts as a tick (legal, used in test).
- btn_lvl changes only together with btn_press or btn_release.

Decomposition:
- Shared package:
  - state enum (IDLE, DEB_DN, PRESSED, HELD, DEB_UP)
  - default ms constants
  - width helper function for counter sizing
- One natural sub-module: sync_2ff (parameterisable-width 2-flop synchroniser, reset to 0), reusable for other board inputs.
- FSM, counters and pulse registers stay in btn_debounce_ms.

Test Plan:
Bench uses T_DEB=4, T_LONG=20, T_REP=5, with ce1ms driven every 10 clk.
- Clean press: btn_in 0->1 held 100 clk -> btn_press single pulse after 4th ce1ms seen in DEB_DN (30..40 clk + 3 after edge); btn_lvl=1 thereafter; no other pulses.
- Glitch rejection: btn_in high for 25 clk, then low -> no pulse, btn_lvl stays 0, FSM returns to IDLE; s1=0 coinciding with ce1ms also aborts.
- Bouncy release: from pressed, toggle btn_in 1/0 every 7 clk for 60 clk, then hold low -> exactly one btn_release, 4 ticks after last bounce; btn_press not re-issued.
- Long-press and repeat: hold 400 clk -> btn_long once at 20th tick after press; btn_rep at ticks +5, +10, +15 (3 pulses in 15 ticks); release -> btn_release, no further btn_rep.
- Reset mid-hold: assert rst for 1 clk while HELD -> next cycle all outputs 0, state IDLE, no btn_release; with btn_in still high, a fresh btn_press follows after 4 ticks.
- ce1ms tied high: press -> btn_press 4+3 clk after edge; confirms per-tick counting and counter wrap at T_REP.

Source files
------------

// File: rtl/btn_debounce_ms_pkg.sv
// Shared types, default timing constants and counter sizing helper for the
// millisecond-based push-button debouncer.
package btn_debounce_ms_pkg;

  // Button FSM states:
  // ST_IDLE     - button released and stable
  // ST_DEB_DN   - raw level went high, waiting for it to stay high
  // ST_PRESSED  - debounced press, counting hold time towards long-press
  // ST_HELD     - long-press declared, generating auto-repeat pulses
  // ST_DEB_UP   - raw level went low, waiting for it to stay low
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DEB_DN  = 3'd1,
    ST_PRESSED = 3'd2,
    ST_HELD    = 3'd3,
    ST_DEB_UP  = 3'd4
  } state_e;

  // Default timing, all in ce1ms ticks (milliseconds)
  localparam int DEF_T_DEB  = 20;
  localparam int DEF_T_LONG = 1000;
  localparam int DEF_T_REP  = 200;

  // Number of bits needed to hold any value in 0..maxVal.
  // Never returns less than one bit so degenerate values still give a legal
  // vector width.
  function automatic int cnt_width(input int maxVal);
    if (maxVal < 2) begin
      return 1;
    end
    return $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/btn_debounce_ms_sync_2ff.sv
// Two-flop synchroniser for asynchronous board inputs. Every bit is
// synchronised independently, so only use a width > 1 for unrelated
// single-bit signals (buttons, switches), never for a multi-bit bus value.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] s0_q;
  logic [WIDTH-1:0] s1_q;

  // First flop may go metastable; second flop gives it a full cycle to settle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s0_q <= '0;
      s1_q <= '0;
    end else begin
      s0_q <= d_i;
      s1_q <= s0_q;
    end
  end

  assign q_o = s1_q;

endmodule

// File: rtl/btn_debounce_ms.sv
// Push-button debouncer timed by a 1 ms clock-enable strobe.
// Produces a clean button level plus single-cycle press, release,
// long-press and auto-repeat pulses. The raw input is synchronised first and
// the FSM only ever looks at the synchronised copy. All timing is counted in
// ce1ms ticks so the block is independent of the system clock frequency.
module btn_debounce_ms
  import btn_debounce_ms_pkg::*;
#(
  parameter int T_DEB  = DEF_T_DEB,
  parameter int T_LONG = DEF_T_LONG,
  parameter int T_REP  = DEF_T_REP
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ce1ms_i,
  input  logic btn_in_i,
  output logic btn_lvl_o,
  output logic btn_press_o,
  output logic btn_release_o,
  output logic btn_long_o,
  output logic btn_rep_o
);

  // Each counter only has to reach its terminal value (interval - 1); it is
  // reloaded or the state changes on that tick, so no saturation is needed.
  localparam int DW = cnt_width(T_DEB - 1);
  localparam int HW = cnt_width(T_LONG - 1);
  localparam int RW = cnt_width(T_REP - 1);

  localparam logic [DW-1:0] DEB_LAST  = DW'(T_DEB - 1);
  localparam logic [HW-1:0] LONG_LAST = HW'(T_LONG - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(T_REP - 1);

  // Synchronised button level; the only view of the pin the FSM gets
  logic btnSync;

  // Architectural state
  state_e        state_q,   state_d;
  logic [DW-1:0] dcnt_q,    dcnt_d;
  logic [HW-1:0] hcnt_q,    hcnt_d;
  logic [RW-1:0] rcnt_q,    rcnt_d;
  logic          held_q,    held_d;

  // Registered outputs
  logic          lvl_q,     lvl_d;
  logic          press_q,   press_d;
  logic          release_q, release_d;
  logic          long_q,    long_d;
  logic          rep_q,     rep_d;

  sync_2ff #(
    .WIDTH (1)
  ) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (btn_in_i),
    .q_o   (btnSync)
  );

  // Next-state, counter and pulse logic. Pulses default low so each one is
  // exactly one clock wide. A low synchronised level is always checked before
  // the tick strobe so a release or glitch wins over a coincident tick.
  always_comb begin
    state_d   = state_q;
    dcnt_d    = dcnt_q;
    hcnt_d    = hcnt_q;
    rcnt_d    = rcnt_q;
    held_d    = held_q;
    lvl_d     = lvl_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    rep_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (btnSync) begin
          state_d = ST_DEB_DN;
          dcnt_d  = '0;
        end
      end

      ST_DEB_DN: begin
        if (!btnSync) begin
          state_d = ST_IDLE;
        end else if (ce1ms_i) begin
          if (dcnt_q == DEB_LAST) begin
            state_d = ST_PRESSED;
            lvl_d   = 1'b1;
            press_d = 1'b1;
            hcnt_d  = '0;
            held_d  = 1'b0;
          end else begin
            dcnt_d = dcnt_q + DW'(1);
          end
        end
      end

      ST_PRESSED: begin
        if (!btnSync) begin
          state_d = ST_DEB_UP;
          dcnt_d  = '0;
        end else if (ce1ms_i) begin
          if (hcnt_q == LONG_LAST) begin
            state_d = ST_HELD;
            long_d  = 1'b1;
            rcnt_d  = '0;
            held_d  = 1'b1;
          end else begin
            hcnt_d = hcnt_q + HW'(1);
          end
        end
      end

      ST_HELD: begin
        if (!btnSync) begin
          state_d = ST_DEB_UP;
          dcnt_d  = '0;
        end else if (ce1ms_i) begin
          if (rcnt_q == REP_LAST) begin
            rep_d  = 1'b1;
            rcnt_d = '0;
          end else begin
            rcnt_d = rcnt_q + RW'(1);
          end
        end
      end

      ST_DEB_UP: begin
        // Hold and repeat counters stay frozen here so a bounce on release
        // resumes timing where it left off instead of restarting it.
        if (btnSync) begin
          state_d = held_q ? ST_HELD : ST_PRESSED;
        end else if (ce1ms_i) begin
          if (dcnt_q == DEB_LAST) begin
            state_d   = ST_IDLE;
            lvl_d     = 1'b0;
            release_d = 1'b1;
          end else begin
            dcnt_d = dcnt_q + DW'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters and output registers; reset drops everything silently
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      dcnt_q    <= '0;
      hcnt_q    <= '0;
      rcnt_q    <= '0;
      held_q    <= 1'b0;
      lvl_q     <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      rep_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      dcnt_q    <= dcnt_d;
      hcnt_q    <= hcnt_d;
      rcnt_q    <= rcnt_d;
      held_q    <= held_d;
      lvl_q     <= lvl_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      rep_q     <= rep_d;
    end
  end

  assign btn_lvl_o     = lvl_q;
  assign btn_press_o   = press_q;
  assign btn_release_o = release_q;
  assign btn_long_o    = long_q;
  assign btn_rep_o     = rep_q;

endmodule

// File: tb/tb_btn_debounce_ms.sv
// Self-checking bench for btn_debounce_ms with short timing parameters.
// A behavioural model describes the button in terms of "how long has the
// synchronised level disagreed with the debounced level" and "how many ticks
// has the button been held", and is compared against the DUT every cycle.
module tb_btn_debounce_ms;

  localparam int T_DEB  = 4;
  localparam int T_LONG = 20;
  localparam int T_REP  = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce1ms = 1'b0;
  logic btnIn = 1'b0;
  logic btnLvl, btnPress, btnRelease, btnLong, btnRep;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit ceTied = 1'b0;

  // Behavioural reference model state
  bit mS0 = 0, mS1 = 0;
  bit mLvl = 0, mPending = 0, mLongDone = 0;
  int mRun = 0, mHold = 0, mRep = 0;
  bit mPress = 0, mRelease = 0, mLong = 0, mRepP = 0;

  // Pulse statistics observed from the DUT, per scenario
  int nPress = 0, nRelease = 0, nLong = 0, nRep = 0;
  int lastPressCyc = 0;
  int driveCyc = 0;

  always #5 clk = ~clk;

  btn_debounce_ms #(
    .T_DEB  (T_DEB),
    .T_LONG (T_LONG),
    .T_REP  (T_REP)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .ce1ms_i       (ce1ms),
    .btn_in_i      (btnIn),
    .btn_lvl_o     (btnLvl),
    .btn_press_o   (btnPress),
    .btn_release_o (btnRelease),
    .btn_long_o    (btnLong),
    .btn_rep_o     (btnRep)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0d, expected %0d (cycle %0d)",
               tag, observed, expected, cyc);
    end
  endtask

  // One clock edge of the reference model, using the inputs the DUT samples
  task automatic modelStep();
    if (rst) begin
      mS0 = 0; mS1 = 0; mLvl = 0; mPending = 0; mLongDone = 0;
      mRun = 0; mHold = 0; mRep = 0;
      mPress = 0; mRelease = 0; mLong = 0; mRepP = 0;
    end else begin
      mPress = 0; mRelease = 0; mLong = 0; mRepP = 0;
      if (mS1 != mLvl) begin
        if (!mPending) begin
          mPending = 1;
          mRun = 0;
        end else if (ce1ms) begin
          mRun++;
          if (mRun == T_DEB) begin
            mPending = 0;
            mLvl = mS1;
            if (mLvl) begin
              mPress = 1;
              mHold = 0;
              mLongDone = 0;
            end else begin
              mRelease = 1;
            end
          end
        end
      end else if (mPending) begin
        mPending = 0;
      end else if (mLvl && ce1ms) begin
        if (!mLongDone) begin
          mHold++;
          if (mHold == T_LONG) begin
            mLong = 1;
            mLongDone = 1;
            mRep = 0;
          end
        end else begin
          mRep++;
          if (mRep == T_REP) begin
            mRepP = 1;
            mRep = 0;
          end
        end
      end
      mS1 = mS0;
      mS0 = btnIn;
    end
  endtask

  // Drive a constant button/reset level for n cycles, checking every cycle
  task automatic applyStimulus(input logic btnVal, input logic rstVal, input int n);
    for (int i = 0; i < n; i++) begin
      btnIn = btnVal;
      rst   = rstVal;
      ce1ms = ceTied ? 1'b1 : ((cyc % 10) == 9);
      @(posedge clk);
      modelStep();
      #1;
      checkOutput("outputs", {27'd0, btnLvl, btnPress, btnRelease, btnLong, btnRep},
                  {27'd0, mLvl, mPress, mRelease, mLong, mRepP});
      if (btnPress) begin
        nPress++;
        lastPressCyc = cyc;
      end
      if (btnRelease) nRelease++;
      if (btnLong) nLong++;
      if (btnRep) nRep++;
      cyc++;
    end
  endtask

  task automatic clearCounts();
    nPress = 0; nRelease = 0; nLong = 0; nRep = 0;
  endtask

  initial begin
    int pressDelay;

    // Reset
    applyStimulus(1'b0, 1'b1, 3);
    checkOutput("reset_lvl", {31'd0, btnLvl}, 32'd0);
    checkOutput("reset_pulses", {28'd0, btnPress, btnRelease, btnLong, btnRep}, 32'd0);
    applyStimulus(1'b0, 1'b0, 20);

    // Clean press
    clearCounts();
    driveCyc = cyc;
    applyStimulus(1'b1, 1'b0, 100);
    pressDelay = lastPressCyc - driveCyc + 1;
    checkOutput("clean_press_count", nPress, 1);
    checkOutput("clean_press_delay_ok", {31'd0, (pressDelay >= 34 && pressDelay <= 43)}, 1);
    checkOutput("clean_other_pulses", nRelease + nLong + nRep, 0);
    checkOutput("clean_lvl_high", {31'd0, btnLvl}, 1);

    // Bouncy release: 7-clk alternating chunks starting low, then steady low
    clearCounts();
    for (int j = 0; j < 60; j += 7) begin
      applyStimulus(((j / 7) % 2) == 1, 1'b0, (60 - j < 7) ? (60 - j) : 7);
    end
    applyStimulus(1'b0, 1'b0, 80);
    checkOutput("bounce_release_count", nRelease, 1);
    checkOutput("bounce_no_repress", nPress, 0);
    checkOutput("bounce_lvl_low", {31'd0, btnLvl}, 0);

    // Glitch shorter than the debounce interval
    clearCounts();
    applyStimulus(1'b1, 1'b0, 25);
    applyStimulus(1'b0, 1'b0, 40);
    checkOutput("glitch_no_pulses", nPress + nRelease + nLong + nRep, 0);
    checkOutput("glitch_lvl_low", {31'd0, btnLvl}, 0);

    // Long press with auto-repeat
    clearCounts();
    applyStimulus(1'b1, 1'b0, 400);
    checkOutput("long_press_count", nPress, 1);
    checkOutput("long_count", nLong, 1);
    checkOutput("long_rep_count", nRep, 3);
    applyStimulus(1'b0, 1'b0, 80);
    checkOutput("long_release_count", nRelease, 1);
    checkOutput("long_no_late_rep", nRep, 3);

    // Reset while held, button kept high
    clearCounts();
    applyStimulus(1'b1, 1'b0, 250);
    checkOutput("rsthold_long_seen", nLong, 1);
    clearCounts();
    applyStimulus(1'b1, 1'b1, 1);
    checkOutput("rsthold_outputs_zero",
                {27'd0, btnLvl, btnPress, btnRelease, btnLong, btnRep}, 32'd0);
    applyStimulus(1'b1, 1'b0, 60);
    checkOutput("rsthold_fresh_press", nPress, 1);
    checkOutput("rsthold_no_release", nRelease, 0);
    applyStimulus(1'b0, 1'b0, 80);

    // Randomised button activity with occasional resets
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 19) == 0) begin
        applyStimulus(1'($urandom_range(0, 1)), 1'b1, 1);
      end
      applyStimulus(1'($urandom_range(0, 1)), 1'b0, $urandom_range(1, 60));
    end
    applyStimulus(1'b0, 1'b0, 80);
    checkOutput("random_end_lvl_low", {31'd0, btnLvl}, 0);

    // ce1ms tied high: every clock is a tick
    ceTied = 1'b1;
    applyStimulus(1'b0, 1'b0, 10);
    clearCounts();
    driveCyc = cyc;
    applyStimulus(1'b1, 1'b0, 60);
    checkOutput("cetied_press_delay", lastPressCyc - driveCyc + 1, 7);
    checkOutput("cetied_long_count", nLong, 1);
    checkOutput("cetied_rep_count", nRep, 6);
    clearCounts();
    applyStimulus(1'b0, 1'b0, 20);
    checkOutput("cetied_release_count", nRelease, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
